// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan
//   Display back end for the 8-bit counter. A LOAD strobe captures QDATA,
//   a sequential shift-add-3 engine converts it to three BCD digits, and a
//   scanner multiplexes those digits onto a common-anode 7-segment display,
//   advancing one digit per rising edge of the divided clock SCAN_IN.
//
// Parameters
//   SYNC_STAGES : synchronizer depth for SCAN_IN (>= 2)
//
// Ports
//   CCK     in   1  system clock, rising edge
//   CCLR    in   1  asynchronous active-high reset
//   QDATA   in   8  binary value from the counter
//   LOAD    in   1  synchronous load strobe
//   SCAN_IN in   1  divided scan clock, asynchronous level
//   BUSY    out  1  conversion in progress
//   BCD     out 12  displayed value {hundreds, tens, units}
//   SEG     out  7  segments a..g, active-low
//   DIG     out  3  digit enables, active-low, DIG[0] = units
//
// Build option
//   SEG_LZB_EN : when defined, blank leading-zero hundreds/tens digits.

module bcd_seg_scan #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        CCK,
  input  logic        CCLR,
  input  logic [7:0]  QDATA,
  input  logic        LOAD,
  input  logic        SCAN_IN,
  output logic        BUSY,
  output logic [11:0] BCD,
  output logic [6:0]  SEG,
  output logic [2:0]  DIG
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Conversion engine state
  state_t      r_state;
  logic [7:0]  r_bin;
  logic [7:0]  r_hold;
  logic [11:0] r_scratch;
  logic [11:0] r_bcd;
  logic [2:0]  r_iter;
  logic        r_pending;
  logic        r_busy;

  // Scan path state
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_scan_d;
  logic [1:0]             r_idx;
  logic [6:0]             r_seg;
  logic [2:0]             r_dig;

  logic [11:0] w_adj;
  logic        w_rise;
  logic [3:0]  w_nib;
  logic [2:0]  w_dig_on;
  logic        w_blank;

  // Active-low segment pattern for one decimal digit (a = bit 0).
  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Add-3 correction, each nibble independent (no inter-nibble carry).
  always_comb begin
    w_adj = r_scratch;
    for (int unsigned n = 0; n < 3; n++) begin
      if (r_scratch[4*n +: 4] >= 4'd5)
        w_adj[4*n +: 4] = r_scratch[4*n +: 4] + 4'd3;
    end
  end

  always_ff @(posedge CCK or posedge CCLR) begin
    if (CCLR) begin
      r_state   <= ST_IDLE;
      r_bin     <= '0;
      r_hold    <= '0;
      r_scratch <= '0;
      r_bcd     <= '0;
      r_iter    <= '0;
      r_pending <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (LOAD) begin
            r_bin     <= QDATA;
            r_scratch <= '0;
            r_iter    <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_scratch <= {w_adj[10:0], r_bin[7]};
          r_bin     <= {r_bin[6:0], 1'b0};
          r_iter    <= r_iter + 3'd1;
          if (r_iter == 3'd7)
            r_state <= ST_DONE;
          if (LOAD) begin
            r_hold    <= QDATA;
            r_pending <= 1'b1;
          end
        end
        ST_DONE: begin
          r_bcd <= r_scratch;
          // A LOAD arriving in this very cycle counts as pending and, being
          // the newest, supersedes the held value.
          if (LOAD || r_pending) begin
            r_bin     <= LOAD ? QDATA : r_hold;
            r_scratch <= '0;
            r_iter    <= '0;
            r_pending <= 1'b0;
            r_state   <= ST_SHIFT;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_rise = r_sync[SYNC_STAGES-1] & ~r_scan_d;

  // r_idx names the digit that the next scan advance will light.
  always_comb begin
    w_nib    = r_bcd[3:0];
    w_dig_on = 3'b110;
    case (r_idx)
      2'd1: begin
        w_nib    = r_bcd[7:4];
        w_dig_on = 3'b101;
      end
      2'd2: begin
        w_nib    = r_bcd[11:8];
        w_dig_on = 3'b011;
      end
      default: begin
        w_nib    = r_bcd[3:0];
        w_dig_on = 3'b110;
      end
    endcase
`ifdef SEG_LZB_EN
    w_blank = ((r_idx == 2'd2) && (r_bcd[11:8] == 4'd0)) ||
              ((r_idx == 2'd1) && (r_bcd[11:4] == 8'd0));
`else
    w_blank = 1'b0;
`endif
  end

  always_ff @(posedge CCK or posedge CCLR) begin
    if (CCLR) begin
      r_sync   <= '0;
      r_scan_d <= 1'b0;
      r_idx    <= 2'd0;
      r_seg    <= '1;
      r_dig    <= '1;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], SCAN_IN};
      r_scan_d <= r_sync[SYNC_STAGES-1];
      if (w_rise) begin
        r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
        if (w_blank) begin
          r_seg <= '1;
          r_dig <= '1;
        end else begin
          r_seg <= f_seg(w_nib);
          r_dig <= w_dig_on;
        end
      end
    end
  end

  assign BUSY = r_busy;
  assign BCD  = r_bcd;
  assign SEG  = r_seg;
  assign DIG  = r_dig;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Testbench for bcd_seg_scan: directed and randomized conversions and scan
// steps checked against a decimal-arithmetic reference model.
module tb_bcd_seg_scan;

  logic        CCK = 1'b0;
  logic        CCLR;
  logic [7:0]  QDATA;
  logic        LOAD;
  logic        SCAN_IN;
  logic        BUSY;
  logic [11:0] BCD;
  logic [6:0]  SEG;
  logic [2:0]  DIG;

  int n_pass  = 0;
  int n_total = 0;

  // Displayed-state model: next slot to light and the currently shown pattern.
  int         slot;
  logic [2:0] exp_dig;
  logic [6:0] exp_seg;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  bcd_seg_scan #(.SYNC_STAGES(2)) dut (
    .CCK    (CCK),
    .CCLR   (CCLR),
    .QDATA  (QDATA),
    .LOAD   (LOAD),
    .SCAN_IN(SCAN_IN),
    .BUSY   (BUSY),
    .BCD    (BCD),
    .SEG    (SEG),
    .DIG    (DIG)
  );

  always #5 CCK = ~CCK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CCK);
    @(negedge CCK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'(v / 100);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  // One conversion from idle: BUSY must last exactly 9 cycles.
  task automatic do_conv(input int v);
    int cyc;
    QDATA = v[7:0];
    LOAD  = 1'b1;
    tick();
    LOAD  = 1'b0;
    chk("busy_rise", BUSY, 1);
    cyc = 0;
    while (BUSY === 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
    chk("busy_len", cyc, 9);
    chk("bcd_value", BCD, to_bcd(v));
  endtask

  // One SCAN_IN pulse; the display must change on the third edge only.
  task automatic scan_step(input int v);
    int d;
    logic blank;
    SCAN_IN = 1'b1;
    tick();
    tick();
    chk("scan_hold_dig", DIG, exp_dig);
    chk("scan_hold_seg", SEG, exp_seg);
    tick();
    d = (slot == 0) ? v % 10 : (slot == 1) ? (v / 10) % 10 : v / 100;
    blank = 1'b0;
`ifdef SEG_LZB_EN
    blank = (slot == 2 && v < 100) || (slot == 1 && v < 10);
`endif
    if (blank) begin
      exp_dig = 3'b111;
      exp_seg = 7'h7F;
    end else begin
      exp_dig = ~(3'b001 << slot);
      exp_seg = seg_tab[d];
    end
    slot = (slot + 1) % 3;
    chk("scan_dig", DIG, exp_dig);
    chk("scan_seg", SEG, exp_seg);
    tick();
    SCAN_IN = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int a;
    int b;
    int v;
    int busy_n;
    bit seen42;
    CCLR    = 1'b1;
    QDATA   = '0;
    LOAD    = 1'b0;
    SCAN_IN = 1'b0;
    slot    = 0;
    exp_dig = 3'b111;
    exp_seg = 7'h7F;

    // Reset held while SCAN_IN toggles.
    for (int i = 0; i < 12; i++) begin
      SCAN_IN = i[1];
      tick();
      if (i % 4 == 3) begin
        chk("rst_seg", SEG, 7'h7F);
        chk("rst_dig", DIG, 3'b111);
        chk("rst_busy", BUSY, 0);
        chk("rst_bcd", BCD, 12'h000);
      end
    end
    SCAN_IN = 1'b0;
    repeat (3) tick();
    CCLR = 1'b0;
    tick();

    do_conv(255);
    do_conv(0);
    do_conv(100);

    // Back-to-back loads while busy; the newest value wins.
    busy_n = 0;
    seen42 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      LOAD  = (i == 0 || i == 3 || i == 5);
      QDATA = (i == 0) ? 8'd17 : (i == 3) ? 8'd42 : 8'd99;
      tick();
      LOAD = 1'b0;
      if (BUSY === 1'b1) busy_n++;
      if (BCD === 12'h042) seen42 = 1'b1;
      if (i == 9)  chk("b2b_first", BCD, 12'h017);
      if (i == 17) chk("b2b_busy_end", BUSY, 1);
      if (i == 18) chk("b2b_second", BCD, 12'h099);
    end
    chk("b2b_busy_len", busy_n, 18);
    chk("b2b_no42", seen42, 0);

    // LOAD landing in the DONE cycle restarts without a BUSY gap.
    a = $urandom_range(255);
    b = $urandom_range(255);
    busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      LOAD  = (i == 0 || i == 9);
      QDATA = (i == 0) ? a[7:0] : b[7:0];
      tick();
      LOAD = 1'b0;
      if (BUSY === 1'b1) busy_n++;
      if (i == 9)  chk("done_load_first", BCD, to_bcd(a));
      if (i == 18) chk("done_load_second", BCD, to_bcd(b));
    end
    chk("done_load_busy_len", busy_n, 18);

    // Directed scan of 047.
    do_conv(47);
    repeat (4) scan_step(47);

    // Randomized values; display must hold until the next advance.
    for (int k = 0; k < 6; k++) begin
      v = $urandom_range(255);
      if (k == 0) v = $urandom_range(9);
      do_conv(v);
      chk("no_midslot_refresh", SEG, exp_seg);
      repeat (1 + $urandom_range(3)) scan_step(v);
    end

    // CCLR in the middle of a conversion.
    QDATA = 8'd200;
    LOAD  = 1'b1;
    tick();
    LOAD  = 1'b0;
    repeat (3) tick();
    CCLR = 1'b1;
    #1;
    chk("clr_busy", BUSY, 0);
    chk("clr_bcd", BCD, 12'h000);
    chk("clr_dig", DIG, 3'b111);
    chk("clr_seg", SEG, 7'h7F);
    tick();
    CCLR = 1'b0;
    tick();
    slot    = 0;
    exp_dig = 3'b111;
    exp_seg = 7'h7F;
    do_conv(200);
    repeat (3) scan_step(200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scan.md
# bcd_seg_scan

Display back end for the 8-bit counter: samples the counter's `QDATA` on a load strobe, converts it to three BCD digits with a sequential shift-add-3 engine, and multiplexes the digits onto a common-anode 7-segment display. The digit scan rate comes from the divided clock produced by `clkdiv`. The block sits directly downstream of the counter and the divider, on the same `CCK` clock.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for `SCAN_IN`; legal values are ≥2.

Ports:
- `CCK`, in, 1: system clock; all state updates on its rising edge.
- `CCLR`, in, 1: reset; asynchronous, active-high.
- `QDATA`, in, 8: binary value from the counter.
- `LOAD`, in, 1: synchronous load strobe; sampled high on a `CCK` edge.
- `SCAN_IN`, in, 1: divided clock from `clkdiv`; treated as asynchronous level.
- `BUSY`, out, 1: conversion in progress.
- `BCD`, out, 12: displayed value; `[11:8]` is hundreds, `[7:4]` is tens, `[3:0]` is units.
- `SEG`, out, 7: segments, active-low; `SEG[0]`=a through `SEG[6]`=g.
- `DIG`, out, 3: digit enables, active-low; `DIG[0]` is units, `DIG[2]` is hundreds.

## Operation
- Reset values: `BUSY`=0, `BCD`=12'h000, `SEG`=7'h7F, `DIG`=3'b111, digit index=0, pending=0, FSM=IDLE, synchronizer flops=0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE → SHIFT when `LOAD`=1. Capture `QDATA` into the shift register, clear the scratch BCD, set the iteration count to 0 and `BUSY` to 1.
  - SHIFT: each cycle, add 3 to every scratch nibble ≥5, then shift {scratch,bin} left by 1. After iteration 7, go to DONE.
  - DONE: copy scratch to `BCD`. If pending=1, clear pending and go to SHIFT with the held value. Otherwise go to IDLE and drop `BUSY` to 0.
- `LOAD` while BUSY:
  - The newest `QDATA` is captured into a hold register and pending is set.
  - With several loads while busy, the last one wins.
  - The conversion in progress is never aborted.
- Arithmetic:
  - The scratch register is 12 bits and the result is ≤ 12'h255.
  - Each nibble add is 4-bit; no carry propagates between nibbles.
- Scan path:
  - `SCAN_IN` passes through `SYNC_STAGES` flops plus one edge flop.
  - A rising edge on the synchronized signal advances the digit index 0→1→2→0. Index 2 wraps to 0.
- On each advance, the block registers the new digit's enable and its segment pattern from the current `BCD`. Exactly one `DIG` bit is low.
- Segment patterns, digits 0–9 (active-low, `SEG[6:0]`): 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- A `BCD` update takes effect at the next scan advance. The segment pattern of the currently lit digit is not refreshed mid-slot.

## Timing
- `LOAD` sampled at edge k:
  - `BUSY`=1 after edge k.
  - Shifts occur at edges k+1 to k+8.
  - DONE at edge k+9 writes `BCD`; `BUSY`=0 after edge k+9.
  - Total latency is 9 cycles.
- Back-to-back loads: after a pending restart, `BUSY` stays high without a gap. The second result lands 9 cycles after the first DONE.
- `LOAD` in the DONE cycle sets pending.
- Scan latency with `SYNC_STAGES`=2: `DIG`/`SEG` change 3 `CCK` edges after `SCAN_IN` rises. The minimum `SCAN_IN` high and low time is `SYNC_STAGES`+1 cycles.
- `CCLR` mid-conversion:
  - All state returns to reset values immediately; pending is lost.
  - The first `LOAD` after `CCLR` falls behaves as from IDLE.

## Configuration
- `SEG_LZB_EN` defined (leading-zero blanking):
  - When the scanned digit is hundreds and hundreds=0, force `SEG`=7'h7F and `DIG`=3'b111.
  - When the scanned digit is tens and hundreds=0 and tens=0, apply the same blanking.
  - Units are always shown.
- `SEG_LZB_EN` undefined: all three digits are always driven, including leading zeros.

## Test plan
- Reset: assert `CCLR` with `SCAN_IN` toggling → `SEG`=7'h7F, `DIG`=3'b111, `BUSY`=0, `BCD`=12'h000 throughout.
- `QDATA`=8'd255 with a one-cycle `LOAD` → `BUSY` high for exactly 9 cycles, then `BCD`=12'h255. Repeat with 8'd0 → 12'h000 and 8'd100 → 12'h100.
- `LOAD` with 8'd17, then `LOAD` with 8'd42 and 8'd99 at cycles 3 and 5 → `BCD`=12'h017, then 12'h099. `BUSY` stays continuously high for 18 cycles. The value 42 never appears.
- `BCD`=12'h047, 4 `SCAN_IN` rising edges → `DIG` goes 110, 101, 011, 110 with `SEG` showing 7, 4, 0, 7. Each change lands 3 cycles after the edge.
  - With `SEG_LZB_EN` defined, the hundreds slot instead gives `DIG`=111 and `SEG`=7'h7F.
- `CCLR` pulsed at cycle 4 of a conversion of 8'd200 → `BUSY`=0 and `BCD`=12'h000 immediately. A fresh `LOAD` then yields 12'h200 after 9 cycles.
